// File: rtl/decoder_stage_controller_pkg.sv
// decoder_stage_controller_pkg: shared stage encodings and FSM state type
package decoder_stage_controller_pkg;
  localparam int STAGE_WIDTH = 3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                 = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING  = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                 = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE                = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING              = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID         = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_STREAMING_CORRECTION = 3'd6;
  typedef enum logic [STAGE_WIDTH-1:0] {
    S_IDLE   = STAGE_IDLE,
    S_LOAD   = STAGE_MEASUREMENT_LOADING,
    S_GROW   = STAGE_GROW,
    S_MERGE  = STAGE_MERGE,
    S_PEEL   = STAGE_PEELING,
    S_RESULT = STAGE_RESULT_VALID
  } stage_e;
  // last stage_cnt value of a phase that must be held n cycles
  function automatic logic [7:0] last_cnt(int n);
    return 8'(n - 1);
  endfunction
endpackage

// File: rtl/decoder_stage_controller_if.sv
// decoder_stage_controller_if: start/result handshake plus PU mesh flags and stage broadcast
interface decoder_stage_controller_if
  import decoder_stage_controller_pkg::*;
#(
  parameter int PU_COUNT   = 64,
  parameter int ITER_WIDTH = 8
);
  logic                   start;
  logic                   ready;
  logic [PU_COUNT-1:0]    busy;
  logic [PU_COUNT-1:0]    odd;
  logic [STAGE_WIDTH-1:0] global_stage;
  logic                   result_valid;
  logic                   result_ready;
  logic [ITER_WIDTH-1:0]  growth_iterations;
  logic [31:0]            decode_cycles;
  logic                   iteration_limit_hit;
  modport master (
    input  start, busy, odd, result_ready,
    output ready, global_stage, result_valid, growth_iterations, decode_cycles, iteration_limit_hit
  );
  modport slave (
    output start, busy, odd, result_ready,
    input  ready, global_stage, result_valid, growth_iterations, decode_cycles, iteration_limit_hit
  );
endinterface

// File: rtl/decoder_stage_controller_busy_odd_reducer.sv
// busy_odd_reducer: registered OR-reduction of the per-PU busy and odd flags
module busy_odd_reducer #(
  parameter int PU_COUNT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PU_COUNT-1:0] busy,
  input  logic [PU_COUNT-1:0] odd,
  output logic                any_busy_q,
  output logic                any_odd_q
);
  // sample the mesh-wide flags once per cycle; all decisions use these copies
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      any_busy_q <= 1'b0;
      any_odd_q  <= 1'b0;
    end else begin
      any_busy_q <= |busy;
      any_odd_q  <= |odd;
    end
endmodule

// File: rtl/decoder_stage_controller.sv
// decoder_stage_controller: sequences load/merge/grow/peel across the PU array and hands off the result
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int PU_COUNT      = 64,
  parameter int LOAD_CYCLES   = 1,
  parameter int GROW_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int ITER_WIDTH    = 8,
  parameter int MAX_GROW      = 32
) (
  input logic                         clk,
  input logic                         reset,
  decoder_stage_controller_if.master  bus
);
  localparam logic [7:0]            LOAD_LAST   = last_cnt(LOAD_CYCLES);
  localparam logic [7:0]            GROW_LAST   = last_cnt(GROW_CYCLES);
  localparam logic [7:0]            SETTLE_LAST = last_cnt(SETTLE_CYCLES);
  localparam logic [ITER_WIDTH-1:0] MAX_G       = ITER_WIDTH'(MAX_GROW);
  stage_e     state;
  logic [7:0] stage_cnt;
  logic       any_busy_q, any_odd_q;
  logic       settled;
  busy_odd_reducer #(.PU_COUNT(PU_COUNT)) u_reducer (
    .clk(clk), .reset(reset), .busy(bus.busy), .odd(bus.odd),
    .any_busy_q(any_busy_q), .any_odd_q(any_odd_q)
  );
  // the state register is the broadcast stage, so global_stage is glitch-free
  assign bus.global_stage = state;
  assign bus.ready        = state == S_IDLE;
  assign bus.result_valid = state == S_RESULT;
  assign settled          = stage_cnt >= SETTLE_LAST && !any_busy_q;
  // stage sequencer with per-stage dwell counter and decode statistics
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state                   <= S_IDLE;
      stage_cnt               <= '0;
      bus.growth_iterations   <= '0;
      bus.decode_cycles       <= '0;
      bus.iteration_limit_hit <= 1'b0;
    end else begin
      stage_cnt <= stage_cnt + {7'd0, stage_cnt != 8'hff};
      if (state inside {S_LOAD, S_GROW, S_MERGE, S_PEEL} && bus.decode_cycles != '1)
        bus.decode_cycles <= bus.decode_cycles + 32'd1;
      case (state)
        S_IDLE: if (bus.start) begin
          state                   <= S_LOAD;
          stage_cnt               <= '0;
          bus.growth_iterations   <= '0;
          bus.decode_cycles       <= '0;
          bus.iteration_limit_hit <= 1'b0;
        end
        S_LOAD: if (stage_cnt >= LOAD_LAST) begin
          state     <= S_MERGE;
          stage_cnt <= '0;
        end
        S_MERGE: if (settled) begin
          stage_cnt <= '0;
          if (any_odd_q && bus.growth_iterations < MAX_G) begin
            state                 <= S_GROW;
            bus.growth_iterations <= bus.growth_iterations + 1'b1;
          end else begin
            state <= S_PEEL;
            if (any_odd_q) bus.iteration_limit_hit <= 1'b1;
          end
        end
        S_GROW: if (stage_cnt >= GROW_LAST) begin
          state     <= S_MERGE;
          stage_cnt <= '0;
        end
        S_PEEL: if (settled) begin
          state     <= S_RESULT;
          stage_cnt <= '0;
        end
        S_RESULT: if (bus.result_ready) begin
          state     <= S_IDLE;
          stage_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule
